// File: rtl/seq_log_shifter.sv
// Multi-cycle logarithmic shifter: one shift-by-2^k mux stage per clock, valid/ready in and out.
// Optional rotate hardware is enabled by defining SEQ_LOG_SHIFTER_ROTATE_EN (op 11 otherwise acts as SLL).
module seq_log_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    logic [1:0]       op_q;
    logic [SHW-1:0]   k;
    logic [SHW:0]     amt;
    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_out;
    logic             accept;
    logic             last_stage;
`ifdef SEQ_LOG_SHIFTER_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rotl_v;
`endif

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_stage = (k == K_LAST);

    // Single mux row: the current stage shifts by 2^k only when shamt bit k is set.
    always_comb begin
        amt     = (SHW + 1)'(1) << k;
        sll_v   = data_q << amt;
        srl_v   = data_q >> amt;
        sra_v   = $signed(data_q) >>> amt;
`ifdef SEQ_LOG_SHIFTER_ROTATE_EN
        dbl     = {data_q, data_q} << amt;
        rotl_v  = dbl[2*WIDTH-1:WIDTH];
`endif
        shifted = sll_v;
        case (op_q)
            2'b00:   shifted = sll_v;
            2'b01:   shifted = srl_v;
            2'b10:   shifted = sra_v;
            default: begin
`ifdef SEQ_LOG_SHIFTER_ROTATE_EN
                shifted = rotl_v;
`else
                shifted = sll_v;
`endif
            end
        endcase
        stage_out = shamt_q[k] ? shifted : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_stage) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // out_data is a separate register so the previous result survives the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            k        <= '0;
            out_data <= '0;
        end else if (accept) begin
            data_q  <= in_data;
            shamt_q <= in_shamt;
            op_q    <= in_op;
            k       <= '0;
        end else if (state == SHIFT) begin
            data_q <= stage_out;
            k      <= k + SHW'(1);
            if (last_stage) begin
                out_data <= stage_out;
            end
        end
    end

endmodule

// File: tb/tb_seq_log_shifter.sv
// Directed bench for seq_log_shifter: a 32-bit and an 8-bit instance checked against hand values
// and a bit-level reference model; expectations for op 11 follow SEQ_LOG_SHIFTER_ROTATE_EN.
module tb_seq_log_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid8;
    logic        in_ready;
    logic        in_ready8;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_valid8;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_data8;
    logic        busy;
    logic        busy8;
    logic [7:0]  in_data8;
    logic [2:0]  in_shamt8;

    int vectorCount = 0;
    int missCount   = 0;

    assign in_data8  = in_data[7:0];
    assign in_shamt8 = in_shamt[2:0];

    always #5 clk = ~clk;

    seq_log_shifter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    seq_log_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_shamt(in_shamt8), .in_op(in_op),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .busy(busy8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Bit-by-bit reference: each result bit names its source bit directly.
    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input logic [1:0] op, input int w);
        logic [31:0] r;
        logic [1:0]  eop;
        r   = '0;
        eop = op;
`ifndef SEQ_LOG_SHIFTER_ROTATE_EN
        if (op == 2'b11) eop = 2'b00;
`endif
        for (int i = 0; i < w; i++) begin
            case (eop)
                2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < w) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
                default: r[i] = d[(i - s + w) % w];
            endcase
        end
        return r;
    endfunction

    // Issues one operation, scrambles the inputs right after acceptance, and checks
    // latency, result and (when out_ready is high) the one-cycle out_valid pulse.
    task automatic applyStimulus(input bit narrow, input logic [31:0] d, input logic [4:0] s,
                                 input logic [1:0] op, input logic [31:0] exp, input string tag);
        int lat;
        @(negedge clk);
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        if (narrow) in_valid8 = 1'b1;
        else        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        in_data   = ~d;
        in_shamt  = ~s;
        in_op     = ~op;
        lat = 0;
        while (!(narrow ? out_valid8 : out_valid) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), narrow ? 32'd3 : 32'd5);
        checkOutput({tag, "_data"}, narrow ? {24'h0, out_data8} : out_data, exp);
        if (out_ready) begin
            @(negedge clk);
            checkOutput({tag, "_pulse"}, {31'b0, narrow ? out_valid8 : out_valid}, 32'd0);
            checkOutput({tag, "_rdy"}, {31'b0, narrow ? in_ready8 : in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rotExp32;
        logic [31:0] rotExp8;
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  rop;
        bit          nar;
`ifdef SEQ_LOG_SHIFTER_ROTATE_EN
        rotExp32 = 32'h0000_0003;
        rotExp8  = 32'h0000_00A5;
`else
        rotExp32 = 32'h0000_0002;
        rotExp8  = 32'h0000_00A0;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b1;
        $display("[TB] starting seq_log_shifter bench");

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "sll31");
        applyStimulus(1'b0, 32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F, "sra4");
        applyStimulus(1'b0, 32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F, "srl4");
        applyStimulus(1'b0, 32'h8000_00F0, 5'd0,  2'b10, 32'h8000_00F0, "sra0");
        applyStimulus(1'b0, 32'h8000_0001, 5'd1,  2'b11, rotExp32,      "rotl1");

        // Reset mid-SHIFT with a non-zero previous result in out_data.
        @(negedge clk);
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd3;
        in_op    = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0000_00FF, 5'd8, 2'b00, 32'h0000_FF00, "post_rst");

        // Back-pressure with in_* activity while busy.
        out_ready = 1'b0;
        @(negedge clk);
        in_data  = 32'h1234_5678;
        in_shamt = 5'd8;
        in_op    = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_out_data", out_data, 32'h3456_7800);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // Narrow instance, WIDTH = 8.
        applyStimulus(1'b1, 32'hB4, 5'd3, 2'b00, 32'hA0, "w8_sll");
        applyStimulus(1'b1, 32'hB4, 5'd3, 2'b01, 32'h16, "w8_srl");
        applyStimulus(1'b1, 32'hB4, 5'd3, 2'b10, 32'hF6, "w8_sra");
        applyStimulus(1'b1, 32'hB4, 5'd3, 2'b11, rotExp8, "w8_rotl");

        for (int i = 0; i < 16; i++) begin
            nar = i[0];
            rop = 2'($urandom_range(0, 3));
            if (nar) begin
                rd = {24'h0, 8'($urandom)};
                rs = 5'($urandom_range(0, 7));
                applyStimulus(1'b1, rd, rs, rop, model(rd, int'(rs), rop, 8), "rand8");
            end else begin
                rd = $urandom;
                rs = 5'($urandom_range(0, 31));
                applyStimulus(1'b0, rd, rs, rop, model(rd, int'(rs), rop, 32), "rand32");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
